// File: rtl/apb_arb_pkg.sv
// Shared types for the two-requester APB arbiter: FSM state encoding and
// requester index constants.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } arb_state_t;

  localparam logic REQ_M0 = 1'b0;
  localparam logic REQ_M1 = 1'b1;

endpackage

// File: rtl/apb_arb_rr2.sv
// Two-way round-robin grant selection plus the last-grant flag.
// The flag resets to requester 1, so requester 0 wins the first tie.
module apb_arb_rr2
  import apb_arb_pkg::*;
(
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_update,
  input  logic i_owner,
  output logic o_grant,
  output logic o_any
);

  logic r_last;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_last <= REQ_M1;
    end else if (i_update) begin
      r_last <= i_owner;
    end
  end

  always_comb begin
    o_any = i_req0 | i_req1;
    if (i_req0 && i_req1) begin
      o_grant = ~r_last;
    end else if (i_req1) begin
      o_grant = REQ_M1;
    end else begin
      o_grant = REQ_M0;
    end
  end

endmodule

// File: rtl/apb_arbiter2.sv
// Two-requester APB arbiter driving one shared completer port.
// Define APB_ARB_TIMEOUT_EN to add the ACCESS-phase watchdog (TIMEOUT_CYC).
module apb_arbiter2
  import apb_arb_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYC = 32'd1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_psel,
  input  logic        m0_penable,
  input  logic        m0_pwrite,
  input  logic [31:0] m0_paddr,
  input  logic [2:0]  m0_pprot,
  input  logic [31:0] m0_pwdata,
  input  logic [3:0]  m0_pstrb,
  output logic        m0_pready,
  output logic [31:0] m0_prdata,
  output logic        m0_pslverr,
  input  logic        m1_psel,
  input  logic        m1_penable,
  input  logic        m1_pwrite,
  input  logic [31:0] m1_paddr,
  input  logic [2:0]  m1_pprot,
  input  logic [31:0] m1_pwdata,
  input  logic [3:0]  m1_pstrb,
  output logic        m1_pready,
  output logic [31:0] m1_prdata,
  output logic        m1_pslverr,
  output logic        out_psel,
  output logic        out_penable,
  output logic        out_pwrite,
  output logic [31:0] out_paddr,
  output logic [2:0]  out_pprot,
  output logic [31:0] out_pwdata,
  output logic [3:0]  out_pstrb,
  input  logic        out_pready,
  input  logic [31:0] out_prdata,
  input  logic        out_pslverr
);

  arb_state_t  r_state;
  arb_state_t  w_state_next;
  logic        r_grant;
  logic        w_grant;
  logic        w_any;
  logic        w_access;
  logic        w_done;
  logic        w_timeout;
  logic [1:0]  w_req_sel;
  logic [1:0]  w_rsp_ready;
  logic [1:0]  w_rsp_err;
  logic [31:0] w_rsp_data [2];

  // Requester penables carry no information the arbiter needs.
  logic w_unused;
  assign w_unused = &{1'b0, m0_penable, m1_penable};

  apb_arb_rr2 u_rr2 (
    .i_clock  (clock),
    .i_reset  (reset),
    .i_req0   (m0_psel),
    .i_req1   (m1_psel),
    .i_update (w_done),
    .i_owner  (r_grant),
    .o_grant  (w_grant),
    .o_any    (w_any)
  );

  assign w_access = (r_state == ACCESS);
  assign w_done   = w_access && (out_pready || w_timeout);

`ifdef APB_ARB_TIMEOUT_EN
  logic [31:0] r_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= 32'd0;
    end else if (r_state == IDLE && w_any) begin
      r_cnt <= 32'd0;
    end else if (w_access && !out_pready) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  // Fires in the ACCESS cycle that would bring the count to TIMEOUT_CYC.
  assign w_timeout = w_access && !out_pready && ((r_cnt + 32'd1) >= TIMEOUT_CYC);
`else
  logic w_unused_cfg;
  assign w_unused_cfg = &{1'b0, TIMEOUT_CYC};
  assign w_timeout    = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_grant <= REQ_M0;
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE && w_any) begin
        r_grant <= w_grant;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_next = SETUP;
      SETUP:   w_state_next = ACCESS;
      ACCESS:  if (w_done) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    out_psel    = 1'b0;
    out_penable = 1'b0;
    out_pwrite  = 1'b0;
    out_paddr   = 32'd0;
    out_pprot   = 3'd0;
    out_pwdata  = 32'd0;
    out_pstrb   = 4'd0;
    if (r_state != IDLE) begin
      out_psel    = 1'b1;
      out_penable = w_access;
      if (r_grant == REQ_M1) begin
        out_pwrite = m1_pwrite;
        out_paddr  = m1_paddr;
        out_pprot  = m1_pprot;
        out_pwdata = m1_pwdata;
        out_pstrb  = m1_pstrb;
      end else begin
        out_pwrite = m0_pwrite;
        out_paddr  = m0_paddr;
        out_pprot  = m0_pprot;
        out_pwdata = m0_pwdata;
        out_pstrb  = m0_pstrb;
      end
    end
  end

  assign w_req_sel = {m1_psel, m0_psel};

  // A requester that dropped psel mid-transfer gets no response at all.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
    logic w_owner;
    assign w_owner         = w_access && (r_grant == 1'(gi)) && w_req_sel[gi];
    assign w_rsp_ready[gi] = w_owner && (out_pready || w_timeout);
    assign w_rsp_err[gi]   = w_owner && (w_timeout || out_pslverr);
    assign w_rsp_data[gi]  = (w_owner && !w_timeout) ? out_prdata : 32'd0;
  end

  assign m0_pready  = w_rsp_ready[0];
  assign m0_prdata  = w_rsp_data[0];
  assign m0_pslverr = w_rsp_err[0];
  assign m1_pready  = w_rsp_ready[1];
  assign m1_prdata  = w_rsp_data[1];
  assign m1_pslverr = w_rsp_err[1];

endmodule

// File: tb/tb_apb_arbiter2.sv
// Randomised scoreboard bench for apb_arbiter2 with a transaction-level
// completer/arbitration model; timeout scenario runs when APB_ARB_TIMEOUT_EN is set.
`timescale 1ns/1ps
module tb_apb_arbiter2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        m0_psel = 0, m0_penable = 0, m0_pwrite = 0;
  logic [31:0] m0_paddr = 0, m0_pwdata = 0;
  logic [2:0]  m0_pprot = 0;
  logic [3:0]  m0_pstrb = 0;
  logic        m0_pready, m0_pslverr;
  logic [31:0] m0_prdata;
  logic        m1_psel = 0, m1_penable = 0, m1_pwrite = 0;
  logic [31:0] m1_paddr = 0, m1_pwdata = 0;
  logic [2:0]  m1_pprot = 0;
  logic [3:0]  m1_pstrb = 0;
  logic        m1_pready, m1_pslverr;
  logic [31:0] m1_prdata;
  logic        out_psel, out_penable, out_pwrite;
  logic [31:0] out_paddr, out_pwdata;
  logic [2:0]  out_pprot;
  logic [3:0]  out_pstrb;
  logic        out_pready = 0, out_pslverr = 0;
  logic [31:0] out_prdata = 0;

  always #5 clock = ~clock;

  apb_arbiter2 #(.TIMEOUT_CYC(32'd8)) dut (
    .clock(clock), .reset(reset),
    .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite),
    .m0_paddr(m0_paddr), .m0_pprot(m0_pprot), .m0_pwdata(m0_pwdata), .m0_pstrb(m0_pstrb),
    .m0_pready(m0_pready), .m0_prdata(m0_prdata), .m0_pslverr(m0_pslverr),
    .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite),
    .m1_paddr(m1_paddr), .m1_pprot(m1_pprot), .m1_pwdata(m1_pwdata), .m1_pstrb(m1_pstrb),
    .m1_pready(m1_pready), .m1_prdata(m1_prdata), .m1_pslverr(m1_pslverr),
    .out_psel(out_psel), .out_penable(out_penable), .out_pwrite(out_pwrite),
    .out_paddr(out_paddr), .out_pprot(out_pprot), .out_pwdata(out_pwdata), .out_pstrb(out_pstrb),
    .out_pready(out_pready), .out_prdata(out_prdata), .out_pslverr(out_pslverr)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic        wr;
  } xfer_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  xfer_t pend0[$], pend1[$];
  rsp_t  exp0[$], exp1[$];
  int    grant_log[$];
  int    checks = 0, errors = 0;

  // Directed-test knobs for the completer model
  logic        cfg_fixed = 0, cfg_hang = 0, cfg_err = 0;
  int          cfg_wait = 0;
  logic [31:0] cfg_data = 0;
  int          late_req = 0, late_done = 0;

  // Completer plan for the transfer currently on the bus
  int          plan_wait = 0;
  logic [31:0] plan_data = 0;
  logic        plan_err = 0, plan_hang = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [79:0] pk(input xfer_t t);
    return {8'h0, t.wr, t.prot, t.strb, t.addr, t.wdata};
  endfunction

  function automatic xfer_t rnd_xfer();
    xfer_t t;
    t.addr  = $urandom;
    t.wdata = $urandom;
    t.strb  = 4'($urandom);
    t.prot  = 3'($urandom);
    t.wr    = 1'($urandom);
    return t;
  endfunction

  task automatic drive_m(input int m, input logic sel, input logic en, input xfer_t t);
    if (m == 0) begin
      m0_psel = sel; m0_penable = en; m0_pwrite = t.wr; m0_paddr = t.addr;
      m0_pprot = t.prot; m0_pwdata = t.wdata; m0_pstrb = t.strb;
    end else begin
      m1_psel = sel; m1_penable = en; m1_pwrite = t.wr; m1_paddr = t.addr;
      m1_pprot = t.prot; m1_pwdata = t.wdata; m1_pstrb = t.strb;
    end
  endtask

  // Issue one transfer from requester m; lat counts falling edges until pready.
  task automatic do_xfer(input int m, input xfer_t t, output int lat);
    logic  got;
    xfer_t z;
    z = '{default: '0};
    if (m == 0) pend0.push_back(t); else pend1.push_back(t);
    drive_m(m, 1'b1, 1'b0, t);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 100) begin
      @(negedge clock);
      lat++;
      got = (m == 0) ? m0_pready : m1_pready;
      @(posedge clock);
      #1;
      if (!got) drive_m(m, 1'b1, 1'b1, t);
    end
    drive_m(m, 1'b0, 1'b0, z);
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL xfer_done m%0d: no pready after %0d cycles, required completion", m, lat);
    end
  endtask

  task automatic master_run(input int m, input int n);
    int lat;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock);
        #1;
      end
      do_xfer(m, rnd_xfer(), lat);
    end
  endtask

  // Completer response driver: reacts to the bus just after each rising edge.
  int   acc_idx = 0;
  logic in_acc = 0;
  always @(posedge clock) begin
    #1;
    if (!reset && out_psel && out_penable) begin
      if (!in_acc) begin
        in_acc  = 1'b1;
        acc_idx = 0;
      end else begin
        acc_idx++;
      end
      if (!plan_hang && acc_idx == plan_wait) begin
        out_pready = 1'b1; out_prdata = plan_data; out_pslverr = plan_err;
      end else begin
        out_pready = 1'b0; out_prdata = $urandom; out_pslverr = 1'b0;
      end
    end else begin
      in_acc = 1'b0;
      if (late_req != late_done) begin
        late_done++;
        out_pready = 1'b1; out_prdata = $urandom; out_pslverr = 1'b1;
      end else begin
        out_pready = 1'b0; out_prdata = 32'd0; out_pslverr = 1'b0;
      end
    end
  end

  // Bus/arbitration model: phase sequencing, round-robin winner, payload routing.
  int    c_phase, c_win, prev_phase = 0;
  logic  [1:0] prev_psel = 2'b00;
  logic  prev_pready = 1'b0;
  int    last_m = 1;
  xfer_t cur;
  rsp_t  r;
  always @(negedge clock) begin
    c_phase = !out_psel ? 0 : (out_penable ? 2 : 1);
    if (reset) begin
      pend0.delete(); pend1.delete(); exp0.delete(); exp1.delete();
      last_m  = 1;
      c_phase = 0;
    end else begin
      if (prev_phase == 1) check("setup_one_cycle", 80'(c_phase), 80'd2);
      if (prev_phase == 2 && prev_pready) check("idle_after_done", 80'(c_phase), 80'd0);
`ifndef APB_ARB_TIMEOUT_EN
      if (prev_phase == 2 && !prev_pready) check("access_holds", 80'(c_phase), 80'd2);
`endif
      if (c_phase == 0) begin
        check("idle_outputs", {out_penable, out_pwrite, out_pprot, out_pstrb, out_paddr, out_pwdata,
                               m0_pready, m1_pready}, 80'd0);
      end else if (c_phase == 1) begin
        check("idle_gap", 80'(prev_phase), 80'd0);
        check("setup_had_request", 80'(|prev_psel), 80'd1);
        if (prev_psel == 2'b11) c_win = (last_m == 1) ? 0 : 1;
        else c_win = prev_psel[1] ? 1 : 0;
        last_m = c_win;
        grant_log.push_back(c_win);
        if ((c_win == 0 && pend0.size() == 0) || (c_win == 1 && pend1.size() == 0)) begin
          checks++;
          errors++;
          $display("FAIL grant_owner: bus granted to m%0d with nothing pending", c_win);
        end else begin
          cur = (c_win == 0) ? pend0.pop_front() : pend1.pop_front();
          check("setup_payload", {8'h0, out_pwrite, out_pprot, out_pstrb, out_paddr, out_pwdata}, pk(cur));
          plan_hang = cfg_hang;
          plan_wait = cfg_fixed ? cfg_wait : int'($urandom_range(0, 3));
          plan_data = cfg_fixed ? cfg_data : $urandom;
          plan_err  = cfg_fixed ? cfg_err : ($urandom_range(0, 7) == 0);
          r.data = plan_data;
          r.err  = plan_err;
          if (cfg_hang) begin
            r.data = 32'd0;
            r.err  = 1'b1;
          end
`ifndef APB_ARB_TIMEOUT_EN
          if (!cfg_hang)
`endif
          if (c_win == 0) exp0.push_back(r); else exp1.push_back(r);
        end
      end else begin
        check("access_payload", {8'h0, out_pwrite, out_pprot, out_pstrb, out_paddr, out_pwdata}, pk(cur));
      end
    end
    prev_phase  = c_phase;
    prev_psel   = {m1_psel, m0_psel};
    prev_pready = out_pready;
  end

  // Scoreboard monitor: pops an expected response whenever a requester sees pready.
  rsp_t g;
  always @(negedge clock) begin
    if (reset) begin
      check("reset_outputs", {out_psel, out_penable, out_paddr, m0_pready, m0_prdata, m1_pready, m1_pslverr}, 80'd0);
    end
    if (m0_pready && m1_pready) begin
      checks++;
      errors++;
      $display("FAIL dual_pready: both requesters see pready, required at most one");
    end
    if (m0_pready) begin
      if (exp0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL m0_unexpected: pready=1 with no outstanding transfer, required 0");
      end else begin
        g = exp0.pop_front();
        check("m0_response", {m0_prdata, m0_pslverr}, {g.data, g.err});
        $display("xfer m0 prdata=%08h pslverr=%0b", m0_prdata, m0_pslverr);
      end
      check("m1_quiet", {m1_pready, m1_prdata, m1_pslverr}, 80'd0);
    end
    if (m1_pready) begin
      if (exp1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL m1_unexpected: pready=1 with no outstanding transfer, required 0");
      end else begin
        g = exp1.pop_front();
        check("m1_response", {m1_prdata, m1_pslverr}, {g.data, g.err});
        $display("xfer m1 prdata=%08h pslverr=%0b", m1_prdata, m1_pslverr);
      end
      check("m0_quiet", {m0_pready, m0_prdata, m0_pslverr}, 80'd0);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int    lat0, lat1, n;
    xfer_t t, z;
    z = '{default: '0};
    // Requests held during reset must not leak onto the bus
    m0_psel = 1'b1;
    m1_psel = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_bus_idle", {out_psel, out_penable, m0_pready, m1_pready}, 80'd0);
    drive_m(0, 1'b0, 1'b0, z);
    drive_m(1, 1'b0, 1'b0, z);
    @(posedge clock);
    #1 reset = 1'b0;

    // Simultaneous requests: m0, m1, then m0 again, m1
    n = grant_log.size();
    fork
      do_xfer(0, rnd_xfer(), lat0);
      do_xfer(1, rnd_xfer(), lat1);
    join
    fork
      do_xfer(0, rnd_xfer(), lat0);
      do_xfer(1, rnd_xfer(), lat1);
    join
    check("tie_count", 80'(grant_log.size() - n), 80'd4);
    if (grant_log.size() >= n + 4)
      check("tie_order", {grant_log[n][0], grant_log[n+1][0], grant_log[n+2][0], grant_log[n+3][0]}, 80'b0101);

    // Read with zero wait states
    cfg_fixed = 1'b1; cfg_wait = 0; cfg_data = 32'hDEADBEEF; cfg_err = 1'b0;
    t = rnd_xfer(); t.addr = 32'h1000_0000; t.wr = 1'b0;
    do_xfer(0, t, lat0);
    check("m0_read_latency", 80'(lat0), 80'd3);

    // Write with three wait states
    cfg_wait = 3; cfg_data = 32'h1234_5678;
    t = rnd_xfer(); t.addr = 32'h1000_0004; t.wr = 1'b1; t.wdata = 32'h55AA; t.strb = 4'hF;
    do_xfer(1, t, lat1);
    check("m1_write_latency", 80'(lat1), 80'd6);

    // Slave error lasts for the completing cycle only
    cfg_wait = 1; cfg_err = 1'b1;
    do_xfer(0, rnd_xfer(), lat0);
    @(negedge clock);
    check("pslverr_one_cycle", {m0_pslverr, m0_pready}, 80'd0);
    cfg_err = 1'b0;
    @(posedge clock);
    #1;

`ifdef APB_ARB_TIMEOUT_EN
    cfg_hang = 1'b1;
    do_xfer(0, rnd_xfer(), lat0);
    check("timeout_latency", 80'(lat0), 80'd10);
    @(negedge clock);
    check("timeout_psel_drop", {out_psel, out_penable}, 80'd0);
    cfg_hang = 1'b0;
    late_req++;
    repeat (3) @(posedge clock);
    #1;
`endif

    // Reset between clock edges in the middle of ACCESS
    cfg_hang = 1'b1;
    t = rnd_xfer();
    pend0.push_back(t);
    drive_m(0, 1'b1, 1'b0, t);
    repeat (3) @(negedge clock);
    check("pre_reset_access", {out_psel, out_penable}, 80'b11);
    #2 reset = 1'b1;
    #1 check("reset_async", {out_psel, out_penable, m0_pready, m0_pslverr, m1_pready}, 80'd0);
    drive_m(0, 1'b0, 1'b0, z);
    @(posedge clock);
    @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    cfg_hang = 1'b0;
    cfg_fixed = 1'b0;
    n = grant_log.size();
    fork
      do_xfer(0, rnd_xfer(), lat0);
      do_xfer(1, rnd_xfer(), lat1);
    join
    check("post_reset_count", 80'(grant_log.size() - n), 80'd2);
    if (grant_log.size() >= n + 1)
      check("post_reset_tie", 80'(grant_log[n]), 80'd0);

    // Randomised traffic from both requesters
    fork
      master_run(0, 30);
      master_run(1, 30);
    join
    repeat (4) @(posedge clock);
    check("scoreboard_drained", 80'(exp0.size() + exp1.size()), 80'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
